// File: rtl/bp_common_pkg.sv
// bp_common_pkg
//   Shared layout constants for the host-bridge memory arbiter.
//   The downstream tag (did) carries {zero pad, sequence, requester index};
//   the index field is wider than log2(num_req_p) so that an out-of-range
//   index coming back from memory is detectable. Supports up to 4 requesters.
//   Also holds the performance-counter width and a saturating increment.
package bp_common_pkg;

  localparam int unsigned hb_did_idx_width_gp  = 2;
  localparam int unsigned hb_did_seq_width_gp  = 3;
  localparam int unsigned hb_did_width_gp      = hb_did_idx_width_gp + hb_did_seq_width_gp;
  localparam int unsigned hb_perf_cnt_width_gp = 32;

  typedef struct packed {
    logic [hb_did_seq_width_gp-1:0] seq;
    logic [hb_did_idx_width_gp-1:0] idx;
  } hb_did_s;

  function automatic logic [hb_perf_cnt_width_gp-1:0] hb_sat_inc
    (input logic [hb_perf_cnt_width_gp-1:0] v);
    return (&v) ? v : v + hb_perf_cnt_width_gp'(1);
  endfunction

endpackage

// File: rtl/bp_hb_rr_arb.sv
// bp_hb_rr_arb
//   Round-robin grant with lock. Priority starts one past the last requester
//   whose command transferred (requester 0 highest after reset). Once an
//   offer is visible downstream but not taken, the grant is held on that
//   requester until the transfer.
// Ports:
//   clk_i, reset_i  : clock, asynchronous active-high reset
//   req_v_i         : per-requester valid
//   stall_i         : offer presented downstream and not accepted this cycle
//   xfer_i          : offer accepted this cycle
//   grant_v_o       : a requester is granted
//   grant_idx_o     : granted requester index
module bp_hb_rr_arb
  import bp_common_pkg::*;
#(
  parameter int unsigned num_req_p = 2
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [num_req_p-1:0]           req_v_i,
  input  logic                           stall_i,
  input  logic                           xfer_i,
  output logic                           grant_v_o,
  output logic [hb_did_idx_width_gp-1:0] grant_idx_o
);

  typedef logic [hb_did_idx_width_gp-1:0] idx_t;

  idx_t ptr_q, ptr_d;
  logic lock_q, lock_d;
  idx_t lock_idx_q, lock_idx_d;

  // Two passes: first the requesters at or above the pointer, then wrap.
  always_comb begin
    grant_v_o   = 1'b0;
    grant_idx_o = '0;
    if (lock_q) begin
      grant_idx_o = lock_idx_q;
      for (int unsigned i = 0; i < num_req_p; i++) begin
        if (lock_idx_q == idx_t'(i)) grant_v_o = req_v_i[i];
      end
    end else begin
      for (int unsigned i = 0; i < num_req_p; i++) begin
        if (!grant_v_o && req_v_i[i] && (idx_t'(i) >= ptr_q)) begin
          grant_v_o   = 1'b1;
          grant_idx_o = idx_t'(i);
        end
      end
      for (int unsigned i = 0; i < num_req_p; i++) begin
        if (!grant_v_o && req_v_i[i]) begin
          grant_v_o   = 1'b1;
          grant_idx_o = idx_t'(i);
        end
      end
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (xfer_i) begin
      lock_d = 1'b0;
      if (grant_idx_o == idx_t'(num_req_p - 1)) ptr_d = '0;
      else                                      ptr_d = grant_idx_o + idx_t'(1);
    end else if (stall_i) begin
      lock_d     = 1'b1;
      lock_idx_d = grant_idx_o;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/bp_hb_mem_arbiter.sv
// bp_hb_mem_arbiter
//   Arbitrates I$/D$ fill requests onto one memory command channel and routes
//   memory responses back by the requester index carried in the did tag.
//   Each command is tagged {zero pad, per-requester 3-bit sequence, index};
//   responses must return per requester in sequence order. A response seen
//   with nothing outstanding, a bad index, or an unexpected sequence is
//   accepted, dropped and latches error_o until reset.
//   Optional feature macro: BP_HB_MEM_ARB_PERF_EN adds perf_stall_full_o and
//   perf_stall_ready_o saturating stall counters.
// Ports:
//   clk_i, reset_i                        : clock, asynchronous active-high reset
//   req_v_i / req_ready_and_o             : per-requester request handshake
//   req_addr_i, req_wr_i, req_data_i      : per-requester request fields
//   mem_cmd_v_o / mem_cmd_ready_and_i     : downstream command handshake
//   mem_cmd_addr_o/_wr_o/_data_o/_did_o   : downstream command fields
//   mem_resp_v_i / mem_resp_ready_and_o   : downstream response handshake
//   mem_resp_data_i, mem_resp_did_i       : downstream response fields
//   resp_v_o / resp_ready_and_i           : per-requester response handshake
//   resp_data_o                           : shared response data
//   error_o                               : sticky protocol error
module bp_hb_mem_arbiter
  import bp_common_pkg::*;
#(
  parameter int unsigned num_req_p         = 2,
  parameter int unsigned paddr_width_p     = 42,
  parameter int unsigned data_width_p      = 64,
  parameter int unsigned did_width_p       = 19,
  parameter int unsigned max_outstanding_p = 4
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [num_req_p-1:0]                     req_v_i,
  output logic [num_req_p-1:0]                     req_ready_and_o,
  input  logic [num_req_p-1:0][paddr_width_p-1:0]  req_addr_i,
  input  logic [num_req_p-1:0]                     req_wr_i,
  input  logic [num_req_p-1:0][data_width_p-1:0]   req_data_i,
  output logic                                     mem_cmd_v_o,
  input  logic                                     mem_cmd_ready_and_i,
  output logic [paddr_width_p-1:0]                 mem_cmd_addr_o,
  output logic                                     mem_cmd_wr_o,
  output logic [data_width_p-1:0]                  mem_cmd_data_o,
  output logic [did_width_p-1:0]                   mem_cmd_did_o,
  input  logic                                     mem_resp_v_i,
  output logic                                     mem_resp_ready_and_o,
  input  logic [data_width_p-1:0]                  mem_resp_data_i,
  input  logic [did_width_p-1:0]                   mem_resp_did_i,
  output logic [num_req_p-1:0]                     resp_v_o,
  input  logic [num_req_p-1:0]                     resp_ready_and_i,
  output logic [data_width_p-1:0]                  resp_data_o,
  output logic                                     error_o
`ifdef BP_HB_MEM_ARB_PERF_EN
  ,output logic [hb_perf_cnt_width_gp-1:0]         perf_stall_full_o
  ,output logic [hb_perf_cnt_width_gp-1:0]         perf_stall_ready_o
`endif
);

  localparam int unsigned cnt_w_lp = $clog2(max_outstanding_p + 1);

  typedef logic [hb_did_idx_width_gp-1:0] idx_t;
  typedef logic [hb_did_seq_width_gp-1:0] seq_t;
  typedef logic [cnt_w_lp-1:0]            cnt_t;

  logic                    grant_v;
  idx_t                    grant_idx;
  logic                    cmd_xfer, cmd_stall, at_max;
  logic                    resp_xfer, resp_bad, resp_dec;
  hb_did_s                 resp_did, cmd_did;
  seq_t                    exp_sel, seq_sel;
  logic                    rdy_sel, idx_known;

  logic [num_req_p-1:0][hb_did_seq_width_gp-1:0] seq_q, seq_d;
  logic [num_req_p-1:0][hb_did_seq_width_gp-1:0] exp_q, exp_d;
  cnt_t                    cnt_q, cnt_d;
  logic                    error_q, error_d;

  logic                    unused_did_pad;
  assign unused_did_pad = ^mem_resp_did_i;

  bp_hb_rr_arb #(
    .num_req_p (num_req_p)
  ) rr_arb (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_v_i     (req_v_i),
    .stall_i     (cmd_stall),
    .xfer_i      (cmd_xfer),
    .grant_v_o   (grant_v),
    .grant_idx_o (grant_idx)
  );

  // Response routing and validity check.
  always_comb begin
    resp_did  = hb_did_s'(mem_resp_did_i[hb_did_width_gp-1:0]);
    idx_known = 1'b0;
    exp_sel   = '0;
    rdy_sel   = 1'b0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (resp_did.idx == idx_t'(i)) begin
        idx_known = 1'b1;
        exp_sel   = exp_q[i];
        rdy_sel   = resp_ready_and_i[i];
      end
    end
    resp_bad             = (cnt_q == '0) | !idx_known | (resp_did.seq != exp_sel);
    // Bad responses are swallowed, so they never wait on a requester.
    mem_resp_ready_and_o = !reset_i & (resp_bad | rdy_sel);
    resp_xfer            = mem_resp_v_i & mem_resp_ready_and_o;
    resp_dec             = resp_xfer & (cnt_q != '0);
    resp_v_o             = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      resp_v_o[i] = !reset_i & mem_resp_v_i & !resp_bad & (resp_did.idx == idx_t'(i));
    end
    resp_data_o = mem_resp_data_i;
  end

  // Command issue. A response retiring in the same cycle frees the slot,
  // so issue at the limit is allowed then.
  always_comb begin
    at_max      = (cnt_q == cnt_t'(max_outstanding_p));
    mem_cmd_v_o = !reset_i & grant_v & (!at_max | resp_xfer);
    cmd_xfer    = mem_cmd_v_o & mem_cmd_ready_and_i;
    cmd_stall   = mem_cmd_v_o & !mem_cmd_ready_and_i;

    mem_cmd_addr_o  = '0;
    mem_cmd_wr_o    = 1'b0;
    mem_cmd_data_o  = '0;
    seq_sel         = '0;
    req_ready_and_o = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (grant_idx == idx_t'(i)) begin
        mem_cmd_addr_o     = req_addr_i[i];
        mem_cmd_wr_o       = req_wr_i[i];
        mem_cmd_data_o     = req_data_i[i];
        seq_sel            = seq_q[i];
        req_ready_and_o[i] = cmd_xfer;
      end
    end
    cmd_did.seq   = seq_sel;
    cmd_did.idx   = grant_idx;
    mem_cmd_did_o = did_width_p'(cmd_did);
  end

  always_comb begin
    seq_d   = seq_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    error_d = error_q | (resp_xfer & resp_bad);
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (cmd_xfer && (grant_idx == idx_t'(i)))
        seq_d[i] = seq_q[i] + seq_t'(1);
      if (resp_xfer && !resp_bad && (resp_did.idx == idx_t'(i)))
        exp_d[i] = exp_q[i] + seq_t'(1);
    end
    // Any accepted response retires a slot, dropped ones included, so a
    // misbehaving memory cannot leak the outstanding budget.
    case ({cmd_xfer, resp_dec})
      2'b10:   cnt_d = cnt_q + cnt_t'(1);
      2'b01:   cnt_d = cnt_q - cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      seq_q   <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      seq_q   <= seq_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  assign error_o = error_q;

`ifdef BP_HB_MEM_ARB_PERF_EN
  logic [hb_perf_cnt_width_gp-1:0] perf_full_q, perf_full_d;
  logic [hb_perf_cnt_width_gp-1:0] perf_rdy_q, perf_rdy_d;

  always_comb begin
    perf_full_d = (at_max && (|req_v_i)) ? hb_sat_inc(perf_full_q) : perf_full_q;
    perf_rdy_d  = cmd_stall ? hb_sat_inc(perf_rdy_q) : perf_rdy_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      perf_full_q <= '0;
      perf_rdy_q  <= '0;
    end else begin
      perf_full_q <= perf_full_d;
      perf_rdy_q  <= perf_rdy_d;
    end
  end

  assign perf_stall_full_o  = perf_full_q;
  assign perf_stall_ready_o = perf_rdy_q;
`endif

endmodule

// File: tb/tb_bp_hb_mem_arbiter.sv
// Bench for bp_hb_mem_arbiter: directed stimulus, a cycle-level reference
// model evaluated on every falling edge, and literal spot checks.
module tb_bp_hb_mem_arbiter;

  localparam int N    = 2;
  localparam int PAW  = 42;
  localparam int DW   = 64;
  localparam int DIDW = 19;
  localparam int MAXO = 4;

  logic                   clk = 1'b0;
  logic                   reset_i;
  logic [N-1:0]           req_v_i;
  logic [N-1:0]           req_ready_and_o;
  logic [N-1:0][PAW-1:0]  req_addr_i;
  logic [N-1:0]           req_wr_i;
  logic [N-1:0][DW-1:0]   req_data_i;
  logic                   mem_cmd_v_o;
  logic                   mem_cmd_ready_and_i;
  logic [PAW-1:0]         mem_cmd_addr_o;
  logic                   mem_cmd_wr_o;
  logic [DW-1:0]          mem_cmd_data_o;
  logic [DIDW-1:0]        mem_cmd_did_o;
  logic                   mem_resp_v_i;
  logic                   mem_resp_ready_and_o;
  logic [DW-1:0]          mem_resp_data_i;
  logic [DIDW-1:0]        mem_resp_did_i;
  logic [N-1:0]           resp_v_o;
  logic [N-1:0]           resp_ready_and_i;
  logic [DW-1:0]          resp_data_o;
  logic                   error_o;
`ifdef BP_HB_MEM_ARB_PERF_EN
  logic [31:0]            perf_stall_full_o;
  logic [31:0]            perf_stall_ready_o;
`endif

  always #5 clk = ~clk;

  bp_hb_mem_arbiter #(
    .num_req_p         (N),
    .paddr_width_p     (PAW),
    .data_width_p      (DW),
    .did_width_p       (DIDW),
    .max_outstanding_p (MAXO)
  ) dut (
    .clk_i                (clk),
    .reset_i              (reset_i),
    .req_v_i              (req_v_i),
    .req_ready_and_o      (req_ready_and_o),
    .req_addr_i           (req_addr_i),
    .req_wr_i             (req_wr_i),
    .req_data_i           (req_data_i),
    .mem_cmd_v_o          (mem_cmd_v_o),
    .mem_cmd_ready_and_i  (mem_cmd_ready_and_i),
    .mem_cmd_addr_o       (mem_cmd_addr_o),
    .mem_cmd_wr_o         (mem_cmd_wr_o),
    .mem_cmd_data_o       (mem_cmd_data_o),
    .mem_cmd_did_o        (mem_cmd_did_o),
    .mem_resp_v_i         (mem_resp_v_i),
    .mem_resp_ready_and_o (mem_resp_ready_and_o),
    .mem_resp_data_i      (mem_resp_data_i),
    .mem_resp_did_i       (mem_resp_did_i),
    .resp_v_o             (resp_v_o),
    .resp_ready_and_i     (resp_ready_and_i),
    .resp_data_o          (resp_data_o),
    .error_o              (error_o)
`ifdef BP_HB_MEM_ARB_PERF_EN
    ,.perf_stall_full_o   (perf_stall_full_o)
    ,.perf_stall_ready_o  (perf_stall_ready_o)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_out, m_ptr, m_held;
  int m_seq[4];
  int m_exp[4];
  bit m_err;

  // per-cycle expectations computed from the current inputs
  bit e_cmd_v, e_cmd_fire, e_resp_fire, e_bad, e_mrr;
  int e_g, e_ridx, e_rseq;
  logic [N-1:0] e_req_ready, e_resp_v;

  always @(negedge clk) begin
    bit found;
    int c;
    if (reset_i) begin
      e_cmd_v = 0; e_cmd_fire = 0; e_resp_fire = 0; e_bad = 0; e_mrr = 0;
      e_g = 0; e_ridx = 0; e_rseq = 0; e_req_ready = '0; e_resp_v = '0;
    end else begin
      e_ridx = int'(mem_resp_did_i[1:0]);
      e_rseq = int'(mem_resp_did_i[4:2]);
      e_bad  = (m_out == 0) || (e_ridx >= N) || (e_rseq != m_exp[e_ridx]);
      e_mrr  = e_bad ? 1'b1 : resp_ready_and_i[e_ridx];
      e_resp_fire = mem_resp_v_i && e_mrr;
      e_resp_v = (mem_resp_v_i && !e_bad) ? N'(1 << e_ridx) : '0;
      found = 0;
      e_g = 0;
      if (m_held >= 0) begin
        e_g = m_held;
        found = req_v_i[m_held];
      end else begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (!found && req_v_i[c]) begin found = 1; e_g = c; end
        end
      end
      e_cmd_v     = found && ((m_out < MAXO) || e_resp_fire);
      e_cmd_fire  = e_cmd_v && mem_cmd_ready_and_i;
      e_req_ready = e_cmd_fire ? N'(1 << e_g) : '0;
    end

    chk("cmd_v", 64'(mem_cmd_v_o), 64'(e_cmd_v));
    if (e_cmd_v) begin
      chk("cmd_addr", 64'(mem_cmd_addr_o), 64'(req_addr_i[e_g]));
      chk("cmd_wr",   64'(mem_cmd_wr_o),   64'(req_wr_i[e_g]));
      chk("cmd_data", mem_cmd_data_o,      req_data_i[e_g]);
      chk("cmd_did",  64'(mem_cmd_did_o),  64'(m_seq[e_g] * 4 + e_g));
    end
    chk("req_ready", 64'(req_ready_and_o), 64'(e_req_ready));
    chk("resp_v",    64'(resp_v_o),        64'(e_resp_v));
    if (mem_resp_v_i && !reset_i)
      chk("mem_resp_ready", 64'(mem_resp_ready_and_o), 64'(e_mrr));
    if (e_resp_v != '0)
      chk("resp_data", resp_data_o, mem_resp_data_i);
    chk("error", 64'(error_o), 64'(m_err));
  end

  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      m_out <= 0; m_ptr <= 0; m_held <= -1; m_err <= 0;
      for (int k = 0; k < 4; k++) begin m_seq[k] <= 0; m_exp[k] <= 0; end
    end else begin
      if (e_cmd_fire) begin
        m_seq[e_g] <= (m_seq[e_g] + 1) % 8;
        m_ptr      <= (e_g + 1) % N;
        m_held     <= -1;
      end else if (e_cmd_v) begin
        m_held <= e_g;
      end
      if (e_resp_fire && !e_bad) m_exp[e_ridx] <= (m_exp[e_ridx] + 1) % 8;
      if (e_resp_fire && e_bad)  m_err <= 1;
      m_out <= m_out + (e_cmd_fire ? 1 : 0) - ((e_resp_fire && m_out > 0) ? 1 : 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_v_i = '0; mem_cmd_ready_and_i = 1'b0;
    mem_resp_v_i = 1'b0; mem_resp_did_i = '0; mem_resp_data_i = '0;
    resp_ready_and_i = '0;
  endtask

  task automatic reset_pulse();
    idle();
    reset_i = 1'b1;
    #1;
    chk("lit_rst_cmd_v", 64'(mem_cmd_v_o), 64'd0);
    chk("lit_rst_error", 64'(error_o), 64'd0);
    nxt();
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    idle();
    req_addr_i = '0; req_wr_i = '0; req_data_i = '0;
    nxt(); nxt();
    chk("lit_reset_cmd_v", 64'(mem_cmd_v_o), 64'd0);
    chk("lit_reset_resp_v", 64'(resp_v_o), 64'd0);
    reset_i = 1'b0;

    // Both requesters, memory always ready: grants alternate 0,1,0,1.
    req_addr_i[0] = PAW'(42'h100); req_addr_i[1] = PAW'(42'h200);
    req_wr_i = 2'b10;
    req_data_i[0] = 64'hA0; req_data_i[1] = 64'hB1;
    req_v_i = 2'b11; mem_cmd_ready_and_i = 1'b1;
    #1;
    chk("lit_g0_did", 64'(mem_cmd_did_o), 64'd0);
    chk("lit_g0_ready", 64'(req_ready_and_o), 64'b01);
    chk("lit_g0_addr", 64'(mem_cmd_addr_o), 64'h100);
    nxt(); #1;
    chk("lit_g1_did", 64'(mem_cmd_did_o), 64'd1);
    chk("lit_g1_ready", 64'(req_ready_and_o), 64'b10);
    chk("lit_g1_wr", 64'(mem_cmd_wr_o), 64'd1);
    nxt(); #1;
    chk("lit_g2_did", 64'(mem_cmd_did_o), 64'd4);
    nxt(); #1;
    chk("lit_g3_did", 64'(mem_cmd_did_o), 64'd5);
    nxt(); #1;
    // Four outstanding: fifth command blocked.
    chk("lit_full_blocked", 64'(mem_cmd_v_o), 64'd0);
    chk("lit_full_ready", 64'(req_ready_and_o), 64'd0);
    nxt();
    // Response and pending request in the same cycle at the limit.
    mem_resp_v_i = 1'b1; mem_resp_did_i = DIDW'(0); mem_resp_data_i = 64'h1234;
    resp_ready_and_i = 2'b01;
    #1;
    chk("lit_fullresp_resp_v", 64'(resp_v_o), 64'b01);
    chk("lit_fullresp_cmd_v", 64'(mem_cmd_v_o), 64'd1);
    chk("lit_fullresp_did", 64'(mem_cmd_did_o), 64'd8);
    chk("lit_fullresp_data", resp_data_o, 64'h1234);
    nxt();
    mem_resp_v_i = 1'b0; req_v_i = 2'b01;
    #1;
    chk("lit_still_full", 64'(mem_cmd_v_o), 64'd0);
    nxt();

    // Response to requester 1 back-pressured for two cycles.
    req_v_i = '0;
    mem_resp_v_i = 1'b1; mem_resp_did_i = DIDW'(1); mem_resp_data_i = 64'h5555;
    resp_ready_and_i = 2'b00;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("lit_bp_mem_ready", 64'(mem_resp_ready_and_o), 64'd0);
      chk("lit_bp_resp_v", 64'(resp_v_o), 64'b10);
      chk("lit_bp_data", resp_data_o, 64'h5555);
      nxt();
    end
    resp_ready_and_i = 2'b10;
    #1;
    chk("lit_bp_deliver", 64'(mem_resp_ready_and_o), 64'd1);
    nxt();

    // Drain remaining responses in order.
    resp_ready_and_i = 2'b11;
    mem_resp_did_i = DIDW'(4); nxt();
    mem_resp_did_i = DIDW'(5); nxt();
    mem_resp_did_i = DIDW'(8); nxt();

    // Response with nothing outstanding.
    mem_resp_did_i = DIDW'(12); mem_resp_data_i = 64'hDEAD;
    #1;
    chk("lit_cnt0_resp_v", 64'(resp_v_o), 64'd0);
    chk("lit_cnt0_ready", 64'(mem_resp_ready_and_o), 64'd1);
    nxt();
    mem_resp_v_i = 1'b0;
    #1;
    chk("lit_cnt0_error", 64'(error_o), 64'd1);
    nxt(); nxt(); #1;
    chk("lit_cnt0_sticky", 64'(error_o), 64'd1);
    reset_pulse();

    // Sequence mismatch.
    req_v_i = 2'b01; mem_cmd_ready_and_i = 1'b1; nxt();
    req_v_i = '0;
    mem_resp_v_i = 1'b1; mem_resp_did_i = DIDW'(8); resp_ready_and_i = 2'b11;
    #1;
    chk("lit_seq_resp_v", 64'(resp_v_o), 64'd0);
    nxt();
    mem_resp_v_i = 1'b0;
    #1;
    chk("lit_seq_error", 64'(error_o), 64'd1);
    reset_pulse();

    // Out-of-range index.
    req_v_i = 2'b10; mem_cmd_ready_and_i = 1'b1; nxt();
    req_v_i = '0;
    mem_resp_v_i = 1'b1; mem_resp_did_i = DIDW'(2); resp_ready_and_i = 2'b11;
    #1;
    chk("lit_idx_resp_v", 64'(resp_v_o), 64'd0);
    chk("lit_idx_ready", 64'(mem_resp_ready_and_o), 64'd1);
    nxt();
    mem_resp_v_i = 1'b0;
    #1;
    chk("lit_idx_error", 64'(error_o), 64'd1);
    reset_pulse();

    // Grant lock under back-pressure: requester 1 holds despite 0 arriving.
    req_addr_i[1] = PAW'(42'h2A0); req_data_i[1] = 64'hC3;
    req_v_i = 2'b10; mem_cmd_ready_and_i = 1'b0;
    #1;
    chk("lit_lock1_did", 64'(mem_cmd_did_o), 64'd1);
    nxt();
    req_v_i = 2'b11;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("lit_lock_did", 64'(mem_cmd_did_o), 64'd1);
      chk("lit_lock_addr", 64'(mem_cmd_addr_o), 64'h2A0);
      chk("lit_lock_ready", 64'(req_ready_and_o), 64'd0);
      nxt();
    end
    mem_cmd_ready_and_i = 1'b1;
    #1;
    chk("lit_lock_xfer", 64'(req_ready_and_o), 64'b10);
    nxt();
    req_v_i = 2'b01;
    #1;
    chk("lit_after_lock_did", 64'(mem_cmd_did_o), 64'd0);
    nxt();

    // Reset with two outstanding: outputs drop at once, late response errors.
    req_v_i = 2'b11;
    mem_resp_v_i = 1'b1; mem_resp_did_i = DIDW'(1); resp_ready_and_i = 2'b11;
    reset_i = 1'b1;
    #1;
    chk("lit_midrst_cmd_v", 64'(mem_cmd_v_o), 64'd0);
    chk("lit_midrst_req_ready", 64'(req_ready_and_o), 64'd0);
    chk("lit_midrst_resp_v", 64'(resp_v_o), 64'd0);
    chk("lit_midrst_mem_ready", 64'(mem_resp_ready_and_o), 64'd0);
    nxt();
    reset_i = 1'b0;
    #1;
    chk("lit_late_resp_v", 64'(resp_v_o), 64'd0);
    nxt();
    idle();
    #1;
    chk("lit_late_error", 64'(error_o), 64'd1);
    nxt(); nxt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
